twiddle_multiplier: RTL and testbench
=====================================

TWIDDLE_MULTIPLIER -- requirements
Module: twiddle_multiplier

Interface
REQ-001 Parameter: WIDTH, 16, sample component width, signed two's complement Q1.(WIDTH-1).
REQ-002 Parameter: FRAC, WIDTH-1, fractional bits of the twiddle factor.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  input beat valid.
REQ-006 Port: in_ready  output  1  block accepts beat this cycle.
REQ-007 Port: a_real_i, a_imag_i  input  WIDTH each  butterfly top operand, passed through.
REQ-008 Port: b_real_i, b_imag_i  input  WIDTH each  butterfly bottom operand.
REQ-009 Port: w_real_i, w_imag_i  input  WIDTH each  twiddle factor.
REQ-010 Port: out_valid  output  1  output beat valid.
REQ-011 Port: out_ready  input  1  downstream add/subtract stage accepts beat.
REQ-012 Port: a_real_o, a_imag_o  output  WIDTH each  delayed copy of a, aligned with the product.
REQ-013 Port: bw_real_o, bw_imag_o  output  WIDTH each  rounded, saturated b*w.
REQ-014 Port: ovf_o  output  1  saturation occurred on the current output beat, real or imag.
REQ-015 Port: ovf_sticky_o  output  1  saturation seen since last clear.
REQ-016 Port: clr_sticky  input  1  synchronous clear of ovf_sticky_o.

Function
REQ-017 bw_real = b_r*w_r - b_i*w_i; bw_imag = b_r*w_i + b_i*w_r; products are full 2*WIDTH-bit signed; sums are 2*WIDTH+1 bits.
REQ-018 Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
REQ-019 Saturation: a shifted result above +(2^(WIDTH-1)-1) is clamped to 0x7FFF, and one below -2^(WIDTH-1) is clamped to 0x8000; ovf_o is high for that beat.
REQ-020 Pipeline: stage S1 registers the operands, S2 registers the four products, S3 registers the rounded, saturated result; latency is exactly 3 clk from accept to out_valid with no stall.
REQ-021 A beat is accepted when in_valid and in_ready are both high; it is transferred out when out_valid and out_ready are both high.
REQ-022 Stall: stall = out_valid & ~out_ready; in_ready = ~stall; while stall, all stage registers and valid bits hold.
REQ-023 With stall low, each stage loads its predecessor every cycle; invalid slots (bubbles) propagate as valid=0 and are not collapsed.
REQ-024 Outputs are stable (data, ovf_o) while out_valid=1 and out_ready=0.
REQ-025 Beat order is preserved; no beat is dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 a_*_o travels the same 3 stages as b, bit-exact, unmodified.
REQ-027 ovf_sticky_o is set on any transferred beat with ovf_o=1; clr_sticky clears it; if set and clear occur in the same cycle, set wins.
REQ-028 in_ready is combinational from out_valid and out_ready only, with no path from in_valid.

Reset
REQ-029 On rst_n low, all stage valid bits, out_valid, ovf_o and ovf_sticky_o go to 0 immediately, and all data outputs go to 0.
REQ-030 In-flight beats are discarded on reset mid-operation; in_ready = 1 during and after reset.
REQ-031 After rst_n deasserts, the first accepted beat appears after exactly 3 cycles.

Structure
REQ-032 A shared package fft_pkg holds WIDTH, FRAC, PIPE_LATENCY=3, and the Q1.15 constants SAT_MAX=0x7FFF and SAT_MIN=0x8000.
REQ-033 A single sub-module round_sat (2*WIDTH+1-bit input; WIDTH-bit output plus ovf flag) is instantiated twice, once for real and once for imag.
REQ-034 Valid/stall control is a single chain inside twiddle_multiplier; no FIFO.

Verification
REQ-035 Inputs b=(0x4000,0) and w=(0x4000,0), one beat -> after 3 cycles bw=(0x2000,0x0000), ovf_o=0, a echoed bit-exact.
REQ-036 Inputs b=(0x4000,0) and w=(0,0x7FFF) -> bw=(0x0000,0x4000); b=(0x0001,0), w=(0x4000,0) -> bw_real=0x0001; b=(0xFFFF,0), w=(0x4000,0) -> bw_real=0x0000.
REQ-037 Inputs b=(0x8000,0) and w=(0x8000,0) -> bw_real=0x7FFF, ovf_o=1, ovf_sticky_o=1 afterwards; a clr_sticky pulse -> 0; clr_sticky coincident with a new overflow beat -> remains 1.
REQ-038 Streaming 3 beats, then out_ready=0 for 5 cycles -> in_ready=0 and output held stable; on release, beats arrive in order with no loss or duplication; random in_valid/out_ready soak for 10k beats is checked against a reference model.
REQ-039 rst_n pulled low with 3 beats in flight -> out_valid=0 immediately and nothing emitted after release; a new beat arrives 3 cycles after accept.

Source files
------------

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants for the FFT datapath blocks.
//   WIDTH        : sample component width (signed Q1.(WIDTH-1))
//   FRAC         : fractional bits of the twiddle factor
//   PIPE_LATENCY : accept-to-output latency of twiddle_multiplier in clk
//   SAT_MAX/MIN  : Q1.15 saturation limits
// ---------------------------------------------------------------------------
package fft_pkg;
   localparam int WIDTH        = 16;
   localparam int FRAC         = WIDTH - 1;
   localparam int PIPE_LATENCY = 3;
   localparam logic [15:0] SAT_MAX = 16'h7FFF;
   localparam logic [15:0] SAT_MIN = 16'h8000;
endpackage

// File: rtl/twiddle_multiplier_if.sv
// ---------------------------------------------------------------------------
// twiddle_multiplier_if
// Valid/ready beat interface of the twiddle multiplier.
//   Upstream   : in_valid/in_ready, a_*_i, b_*_i, w_*_i
//   Downstream : out_valid/out_ready, a_*_o, bw_*_o, ovf_o
//   Status     : ovf_sticky_o, clr_sticky
// slave  = the multiplier side, master = the side feeding/draining it.
// ---------------------------------------------------------------------------
interface twiddle_multiplier_if #(
   parameter int WIDTH = fft_pkg::WIDTH
);
   import fft_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_real_i;
   logic [WIDTH-1:0] a_imag_i;
   logic [WIDTH-1:0] b_real_i;
   logic [WIDTH-1:0] b_imag_i;
   logic [WIDTH-1:0] w_real_i;
   logic [WIDTH-1:0] w_imag_i;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] a_real_o;
   logic [WIDTH-1:0] a_imag_o;
   logic [WIDTH-1:0] bw_real_o;
   logic [WIDTH-1:0] bw_imag_o;
   logic             ovf_o;
   logic             ovf_sticky_o;
   logic             clr_sticky;

   modport slave (
      input  in_valid, a_real_i, a_imag_i, b_real_i, b_imag_i, w_real_i, w_imag_i,
      input  out_ready, clr_sticky,
      output in_ready, out_valid, a_real_o, a_imag_o, bw_real_o, bw_imag_o,
      output ovf_o, ovf_sticky_o
   );

   modport master (
      output in_valid, a_real_i, a_imag_i, b_real_i, b_imag_i, w_real_i, w_imag_i,
      output out_ready, clr_sticky,
      input  in_ready, out_valid, a_real_o, a_imag_o, bw_real_o, bw_imag_o,
      input  ovf_o, ovf_sticky_o
   );
endinterface

// File: rtl/round_sat.sv
// ---------------------------------------------------------------------------
// round_sat
// Rounds a full-precision complex-product sum back to WIDTH bits
// (round half up at bit FRAC) and saturates to the signed WIDTH range.
//   din  : 2*WIDTH+1-bit signed sum of two products
//   dout : WIDTH-bit signed rounded/saturated result
//   ovf  : high when dout was clamped
// ---------------------------------------------------------------------------
module round_sat #(
   parameter int WIDTH = fft_pkg::WIDTH,
   parameter int FRAC  = fft_pkg::FRAC
) (
   input  logic signed [2*WIDTH:0]  din,
   output logic signed [WIDTH-1:0]  dout,
   output logic                     ovf
);
   import fft_pkg::*;

   // One guard bit above din so adding the rounding constant never wraps.
   localparam int EW = 2*WIDTH + 2;
   localparam logic signed [EW-1:0] RND  = {{(EW-1){1'b0}}, 1'b1} << (FRAC-1);
   localparam logic signed [EW-1:0] MAXV = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] MINV = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic logic signed [EW-1:0] round_half_up(input logic signed [2*WIDTH:0] v);
      logic signed [EW-1:0] biased;
      biased = $signed({v[2*WIDTH], v}) + RND;
      return biased >>> FRAC;
   endfunction

   // Returns {clamped, value}.
   function automatic logic [WIDTH:0] saturate(input logic signed [EW-1:0] v);
      if (v > MAXV)
         return {1'b1, MAXV[WIDTH-1:0]};
      else if (v < MINV)
         return {1'b1, MINV[WIDTH-1:0]};
      else
         return {1'b0, v[WIDTH-1:0]};
   endfunction

   logic [WIDTH:0] sat;

   assign sat  = saturate(round_half_up(din));
   assign ovf  = sat[WIDTH];
   assign dout = $signed(sat[WIDTH-1:0]);
endmodule

// File: rtl/twiddle_multiplier.sv
// ---------------------------------------------------------------------------
// twiddle_multiplier
// FFT butterfly twiddle stage: bw = b * w (complex), rounded and saturated,
// with the top operand a carried alongside so both leave together.
// Three-stage pipeline (operands, products, rounded result) governed by a
// single valid chain that freezes as a whole while the output is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : twiddle_multiplier_if.slave (handshakes, operands, results,
//                overflow flags, sticky clear)
// ---------------------------------------------------------------------------
module twiddle_multiplier #(
   parameter int WIDTH = fft_pkg::WIDTH,
   parameter int FRAC  = fft_pkg::FRAC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   twiddle_multiplier_if.slave  bus
);
   import fft_pkg::*;

   localparam int PW = 2*WIDTH;

   function automatic logic signed [PW-1:0] sx_prod(input logic signed [WIDTH-1:0] v);
      return {{WIDTH{v[WIDTH-1]}}, v};
   endfunction

   function automatic logic signed [PW:0] sx_sum(input logic signed [PW-1:0] v);
      return {v[PW-1], v};
   endfunction

   logic                    stall;
   logic                    xfer;
   logic                    vld_p1, vld_p2, vld_p3;
   logic signed [WIDTH-1:0] a_re_p1, a_im_p1, b_re_p1, b_im_p1, w_re_p1, w_im_p1;
   logic signed [WIDTH-1:0] a_re_p2, a_im_p2;
   logic signed [PW-1:0]    rr_p2, ii_p2, ri_p2, ir_p2;
   logic signed [PW:0]      sum_re, sum_im;
   logic signed [WIDTH-1:0] rs_re, rs_im;
   logic                    ovf_re, ovf_im;
   logic signed [WIDTH-1:0] a_re_p3, a_im_p3, bw_re_p3, bw_im_p3;
   logic                    ovf_p3;
   logic                    ovf_sticky;

   // in_ready depends only on the output handshake, never on in_valid.
   assign stall        = vld_p3 & ~bus.out_ready;
   assign bus.in_ready = ~stall;
   assign xfer         = vld_p3 & bus.out_ready;

   assign sum_re = sx_sum(rr_p2) - sx_sum(ii_p2);
   assign sum_im = sx_sum(ri_p2) + sx_sum(ir_p2);

   round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rs_re (
      .din  (sum_re),
      .dout (rs_re),
      .ovf  (ovf_re)
   );

   round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rs_im (
      .din  (sum_im),
      .dout (rs_im),
      .ovf  (ovf_im)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         a_re_p1  <= '0;
         a_im_p1  <= '0;
         b_re_p1  <= '0;
         b_im_p1  <= '0;
         w_re_p1  <= '0;
         w_im_p1  <= '0;
         vld_p2   <= 1'b0;
         a_re_p2  <= '0;
         a_im_p2  <= '0;
         rr_p2    <= '0;
         ii_p2    <= '0;
         ri_p2    <= '0;
         ir_p2    <= '0;
         vld_p3   <= 1'b0;
         a_re_p3  <= '0;
         a_im_p3  <= '0;
         bw_re_p3 <= '0;
         bw_im_p3 <= '0;
         ovf_p3   <= 1'b0;
      end else if (!stall) begin
         // ---- S1: operand capture (bubbles enter as vld_p1 = 0) ----
         vld_p1   <= bus.in_valid;
         a_re_p1  <= bus.a_real_i;
         a_im_p1  <= bus.a_imag_i;
         b_re_p1  <= bus.b_real_i;
         b_im_p1  <= bus.b_imag_i;
         w_re_p1  <= bus.w_real_i;
         w_im_p1  <= bus.w_imag_i;
         // ---- S2: four full-precision partial products ----
         vld_p2   <= vld_p1;
         a_re_p2  <= a_re_p1;
         a_im_p2  <= a_im_p1;
         rr_p2    <= sx_prod(b_re_p1) * sx_prod(w_re_p1);
         ii_p2    <= sx_prod(b_im_p1) * sx_prod(w_im_p1);
         ri_p2    <= sx_prod(b_re_p1) * sx_prod(w_im_p1);
         ir_p2    <= sx_prod(b_im_p1) * sx_prod(w_re_p1);
         // ---- S3: rounded, saturated result ----
         vld_p3   <= vld_p2;
         a_re_p3  <= a_re_p2;
         a_im_p3  <= a_im_p2;
         bw_re_p3 <= rs_re;
         bw_im_p3 <= rs_im;
         ovf_p3   <= vld_p2 & (ovf_re | ovf_im);
      end
   end

   // Set has priority over clear so a coincident overflow is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_sticky <= 1'b0;
      else if (xfer && ovf_p3)
         ovf_sticky <= 1'b1;
      else if (bus.clr_sticky)
         ovf_sticky <= 1'b0;
   end

   assign bus.out_valid    = vld_p3;
   assign bus.a_real_o     = a_re_p3;
   assign bus.a_imag_o     = a_im_p3;
   assign bus.bw_real_o    = bw_re_p3;
   assign bus.bw_imag_o    = bw_im_p3;
   assign bus.ovf_o        = ovf_p3;
   assign bus.ovf_sticky_o = ovf_sticky;
endmodule

// File: tb/tb_twiddle_multiplier.sv
// ---------------------------------------------------------------------------
// tb_twiddle_multiplier
// Directed vectors with literal expectations plus a randomized soak, all
// compared every cycle against a behavioural model of the multiplier.
// ---------------------------------------------------------------------------
module tb_twiddle_multiplier;
   import fft_pkg::*;

   typedef struct packed {
      logic        v;
      logic [15:0] are;
      logic [15:0] aim;
      logic [15:0] bre;
      logic [15:0] bim;
      logic        ovf;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   twiddle_multiplier_if #(.WIDTH(WIDTH)) bus ();

   twiddle_multiplier #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int    checks = 0;
   int    errors = 0;
   int    accepted = 0;
   int    transferred = 0;
   beat_t slot [3];
   logic  sticky_m;

   // Round half up by 2^15 then clamp to 16-bit signed; returns {ovf, value}.
   function automatic logic [16:0] round_clamp(input longint s);
      longint r;
      r = (s + 16384) >>> 15;
      if (r > 32767)  return {1'b1, 16'h7FFF};
      if (r < -32768) return {1'b1, 16'h8000};
      return {1'b0, r[15:0]};
   endfunction

   function automatic beat_t ref_beat(input logic [15:0] ar, ai, br, bi, wr, wi);
      longint     lbr, lbi, lwr, lwi;
      logic [16:0] re, im;
      beat_t      bt;
      lbr = longint'($signed(br));
      lbi = longint'($signed(bi));
      lwr = longint'($signed(wr));
      lwi = longint'($signed(wi));
      re = round_clamp(lbr*lwr - lbi*lwi);
      im = round_clamp(lbr*lwi + lbi*lwr);
      bt.v   = 1'b1;
      bt.are = ar;
      bt.aim = ai;
      bt.bre = re[15:0];
      bt.bim = im[15:0];
      bt.ovf = re[16] | im[16];
      return bt;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("out_valid", 32'(bus.out_valid), 32'(slot[2].v));
      if (slot[2].v) begin
         chk("a_real_o",  32'(bus.a_real_o),  32'(slot[2].are));
         chk("a_imag_o",  32'(bus.a_imag_o),  32'(slot[2].aim));
         chk("bw_real_o", 32'(bus.bw_real_o), 32'(slot[2].bre));
         chk("bw_imag_o", 32'(bus.bw_imag_o), 32'(slot[2].bim));
         chk("ovf_o",     32'(bus.ovf_o),     32'(slot[2].ovf));
      end
      chk("ovf_sticky_o", 32'(bus.ovf_sticky_o), 32'(sticky_m));
   endtask

   // One clock: drive after a falling edge, predict the rising edge, compare
   // at the next falling edge.
   task automatic step(input logic iv, input logic [15:0] ar, ai, br, bi, wr, wi,
                       input logic ordy, input logic clr);
      logic stall_m;
      bus.in_valid   = iv;
      bus.a_real_i   = ar;
      bus.a_imag_i   = ai;
      bus.b_real_i   = br;
      bus.b_imag_i   = bi;
      bus.w_real_i   = wr;
      bus.w_imag_i   = wi;
      bus.out_ready  = ordy;
      bus.clr_sticky = clr;
      #1;
      stall_m = slot[2].v && !ordy;
      chk("in_ready", 32'(bus.in_ready), 32'(!stall_m));
      if (slot[2].v && ordy) begin
         transferred++;
         if (slot[2].ovf) sticky_m = 1'b1;
         else if (clr)    sticky_m = 1'b0;
      end else if (clr) begin
         sticky_m = 1'b0;
      end
      if (!stall_m) begin
         slot[2] = slot[1];
         slot[1] = slot[0];
         if (iv) begin
            slot[0] = ref_beat(ar, ai, br, bi, wr, wi);
            accepted++;
         end else begin
            slot[0] = '0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic idle(input int n, input logic ordy, input logic clr);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0, ordy, clr);
   endtask

   task automatic lit(input string name, input logic [15:0] re, im, input logic ovf);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_re"},    32'(bus.bw_real_o), 32'(re));
      chk({name, "_im"},    32'(bus.bw_imag_o), 32'(im));
      chk({name, "_ovf"},   32'(bus.ovf_o),     32'(ovf));
   endtask

   function automatic logic [15:0] rnd16();
      if ($urandom_range(0, 9) == 0)
         return ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
      return 16'($urandom);
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int soak_start;
      int cyc;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.a_real_i   = '0;
      bus.a_imag_i   = '0;
      bus.b_real_i   = '0;
      bus.b_imag_i   = '0;
      bus.w_real_i   = '0;
      bus.w_imag_i   = '0;
      bus.out_ready  = 1'b1;
      bus.clr_sticky = 1'b0;
      for (int i = 0; i < 3; i++) slot[i] = '0;
      sticky_m = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_out_valid", 32'(bus.out_valid),    32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),     32'd1);
      chk("rst_bw_real",   32'(bus.bw_real_o),    32'd0);
      chk("rst_bw_imag",   32'(bus.bw_imag_o),    32'd0);
      chk("rst_a_real",    32'(bus.a_real_o),     32'd0);
      chk("rst_ovf",       32'(bus.ovf_o),        32'd0);
      chk("rst_sticky",    32'(bus.ovf_sticky_o), 32'd0);
      rst_n = 1'b1;

      // 0.5 * 0.5 with a echoed, visible exactly 3 cycles after presentation
      step(1'b1, 16'h1234, 16'hABCD, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      idle(PIPE_LATENCY - 1, 1'b1, 1'b0);
      lit("half_sq", 16'h2000, 16'h0000, 1'b0);
      chk("half_sq_a_re", 32'(bus.a_real_o), 32'h1234);
      chk("half_sq_a_im", 32'(bus.a_imag_o), 32'hABCD);

      // Rotation by j, smallest positive, and -1 LSB rounding to zero
      step(1'b1, 16'h0001, 16'h0002, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
      step(1'b1, 16'h0003, 16'h0004, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h0005, 16'h0006, 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      lit("rot_j", 16'h0000, 16'h4000, 1'b0);
      idle(1, 1'b1, 1'b0);
      lit("lsb_pos", 16'h0001, 16'h0000, 1'b0);
      idle(1, 1'b1, 1'b0);
      lit("lsb_neg", 16'h0000, 16'h0000, 1'b0);
      idle(1, 1'b1, 1'b0);

      // Stream 3 beats, then hold the output for 5 cycles
      step(1'b1, 16'h0101, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h0202, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
      step(1'b1, 16'h0303, 16'h0000, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'h0E0E, 16'h0E0E, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
         lit("stall_hold", 16'h2000, 16'h0000, 1'b0);
         chk("stall_hold_a", 32'(bus.a_real_o), 32'h0101);
      end
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      idle(1, 1'b1, 1'b0);
      lit("release_b2", 16'h0000, 16'h4000, 1'b0);
      chk("release_b2_a", 32'(bus.a_real_o), 32'h0202);
      idle(1, 1'b1, 1'b0);
      lit("release_b3", 16'h0001, 16'h0000, 1'b0);
      idle(3, 1'b1, 1'b0);
      chk("release_drained", 32'(bus.out_valid), 32'd0);

      // Overflow: (-1) * (-1) clamps to 0x7FFF; sticky set / clear / set-wins
      step(1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0);
      idle(2, 1'b1, 1'b0);
      lit("ovf_beat", 16'h7FFF, 16'h0000, 1'b1);
      idle(1, 1'b1, 1'b0);
      chk("sticky_set", 32'(bus.ovf_sticky_o), 32'd1);
      idle(1, 1'b1, 1'b1);
      chk("sticky_clr", 32'(bus.ovf_sticky_o), 32'd0);
      step(1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0);
      idle(2, 1'b1, 1'b0);
      idle(1, 1'b1, 1'b1);
      chk("sticky_set_wins", 32'(bus.ovf_sticky_o), 32'd1);

      // Reset with 3 beats in flight
      step(1'b1, 16'h5555, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h5556, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h5557, 16'h0000, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid),    32'd0);
      chk("midrst_in_ready",  32'(bus.in_ready),     32'd1);
      chk("midrst_sticky",    32'(bus.ovf_sticky_o), 32'd0);
      chk("midrst_bw_real",   32'(bus.bw_real_o),    32'd0);
      for (int i = 0; i < 3; i++) slot[i] = '0;
      sticky_m    = 1'b0;
      transferred = accepted;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4, 1'b1, 1'b0);
      step(1'b1, 16'h7777, 16'h0000, 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b1, 1'b0);
      idle(PIPE_LATENCY - 1, 1'b1, 1'b0);
      lit("post_rst", 16'h0001, 16'h0000, 1'b0);
      chk("post_rst_a", 32'(bus.a_real_o), 32'h7777);

      // Randomized soak
      soak_start = accepted;
      cyc = 0;
      while ((accepted - soak_start) < 10000 && cyc < 60000) begin
         step(($urandom_range(0, 9) < 7), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
         cyc++;
      end
      checks++;
      if ((accepted - soak_start) < 10000) begin
         errors++;
         $display("FAIL soak_budget: accepted %0d beats, required 10000", accepted - soak_start);
      end
      idle(PIPE_LATENCY + 1, 1'b1, 1'b0);
      chk("drain_count", 32'(transferred), 32'(accepted));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
